// File: rtl/apb_req_arbiter_if.sv
// Bundle between the round-robin arbiter, its requesters and the APB upstream
// port of the APB-to-AHB bridge.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ-1:0]    ack;
    logic                  ack_err;
    logic [31:0]           rdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    // bridge side
    logic [31:0]           paddr;
    logic [31:0]           pwdata;
    logic                  pwrite;
    logic                  penable;
    logic                  pready;
    logic [31:0]           prdata;

    // arbiter view
    modport master (
        input  req, req_addr, req_wdata, req_write, pready, prdata,
        output ack, ack_err, rdata, grant_id, busy,
               paddr, pwdata, pwrite, penable
    );

    // requesters + bridge view
    modport slave (
        output req, req_addr, req_wdata, req_write, pready, prdata,
        input  ack, ack_err, rdata, grant_id, busy,
               paddr, pwdata, pwrite, penable
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB upstream port between NUM_REQ requesters,
// one transfer at a time, with a per-transfer watchdog.
module apb_req_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset_,
    apb_req_arbiter_if.master bus
);
    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
    localparam logic [15:0]    WD_LAST  = 16'(TIMEOUT - 1);

    logic [1:0]         state_q,   state_d;
    logic [IDW-1:0]     last_q,    last_d;
    logic [15:0]        wd_cnt_q,  wd_cnt_d;
    logic [NUM_REQ-1:0] ack_q,     ack_d;
    logic               ack_err_q, ack_err_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic               busy_q,    busy_d;
    logic [31:0]        paddr_q,   paddr_d;
    logic [31:0]        pwdata_q,  pwdata_d;
    logic               pwrite_q,  pwrite_d;
    logic               penable_q, penable_d;

    logic [31:0]        addr_w  [NUM_REQ];
    logic [31:0]        wdata_w [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDW-1:0]     win;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_w[gi]       = bus.req_addr[32*gi +: 32];
            assign wdata_w[gi]      = bus.req_wdata[32*gi +: 32];
            assign grant_onehot[gi] = (last_q == IDW'(gi));
        end
    endgenerate

    // Index of the requester k positions after base, wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Walking from the far end back toward last+1 leaves the nearest set bit.
    always_comb begin
        win = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[rr_idx(last_q, k)]) begin
                win = rr_idx(last_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wd_cnt_d  = wd_cnt_q;
        ack_d     = ack_q;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    paddr_d   = addr_w[win];
                    pwdata_d  = wdata_w[win];
                    pwrite_d  = bus.req_write[win];
                    penable_d = 1'b1;
                    busy_d    = 1'b1;
                    last_d    = win;
                    wd_cnt_d  = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion on the expiry cycle still counts as a normal ack.
                if (bus.pready) begin
                    rdata_d   = bus.prdata;
                    ack_d     = grant_onehot;
                    ack_err_d = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_GAP;
                end else if (wd_cnt_q == WD_LAST) begin
                    rdata_d   = ERR_RDATA;
                    ack_d     = grant_onehot;
                    ack_err_d = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_DRAIN;
                end else begin
                    wd_cnt_d  = wd_cnt_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                // The error ack has been given; the late completion is swallowed.
                ack_d     = '0;
                ack_err_d = 1'b0;
                if (bus.pready) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                ack_d     = '0;
                ack_err_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            last_q    <= LAST_RST;
            wd_cnt_q  <= '0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wd_cnt_q  <= wd_cnt_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.rdata    = rdata_q;
    assign bus.grant_id = last_q;
    assign bus.busy     = busy_q;
    assign bus.paddr    = paddr_q;
    assign bus.pwdata   = pwdata_q;
    assign bus.pwrite   = pwrite_q;
    assign bus.penable  = penable_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised bench for apb_req_arbiter: bridge model, requester driver and a
// transfer-level reference model feeding an ack scoreboard.
module tb_apb_req_arbiter;
    localparam int          N   = 3;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int          TAB = 1024;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(N)) bus();

    apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(T), .ERR_RDATA(ERR)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-transfer bridge latency (cycles from first penable cycle to pready)
    // and read data, indexed by transfer number; read by bridge and model alike.
    int          lat_tab [TAB];
    logic [31:0] prd_tab [TAB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- bridge model ----------------
    initial begin
        int          bn;
        bit          bb;
        bit          pen_prev;
        int          t_done;
        bit          np;
        logic [31:0] nd;
        logic [31:0] keep;
        bn = 0; bb = 0; pen_prev = 0; t_done = 0; keep = '0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(negedge clk);
            np = 0;
            nd = $urandom;
            if (!reset_) begin
                bb = 0;
                pen_prev = 0;
            end else begin
                if (bb && cyc == t_done) begin
                    bb = 0;
                    if ($urandom_range(1) == 1) np = 1;   // stray pulse into GAP
                end
                if (!bb && bus.penable && !pen_prev) begin
                    bb = 1;
                    t_done = cyc + lat_tab[bn % TAB];
                    keep = prd_tab[bn % TAB];
                    bn++;
                end
                if (bb && cyc + 1 == t_done) begin
                    np = 1;
                    nd = keep;
                end else if (!bb && !np && !bus.busy && bus.req == '0 &&
                             $urandom_range(4) == 0) begin
                    np = 1;                               // stray pulse in IDLE
                end
                pen_prev = bus.penable;
            end
            @(posedge clk);
            #2;
            bus.pready = np;
            bus.prdata = nd;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          cyc;
        int          id;
        bit          err;
        logic [31:0] rd;
    } exp_t;
    exp_t sbq[$];

    initial begin
        int          last_m, free_from, g, pen_end, gap_c, mn, w, lat;
        bit          pred_p, pen_p, rise;
        logic [N-1:0] req_p;
        logic [N-1:0] wr_p;
        logic [31:0] addr_p [N];
        logic [31:0] wdata_p [N];
        logic [31:0] ea, ed;
        bit          ew;
        exp_t        e;
        mn = 0; last_m = N - 1; free_from = 0; g = -100; pen_end = -100; gap_c = -100;
        pred_p = 0; pen_p = 0; req_p = '0; wr_p = '0; ea = '0; ed = '0; ew = 0;
        forever begin
            @(negedge clk);
            if (!reset_) begin
                last_m = N - 1; free_from = 0; g = -100; pen_end = -100; gap_c = -100;
                pred_p = 0; pen_p = 0;
                sbq.delete();
            end else begin
                rise = bus.penable && !pen_p;
                if (pred_p || rise) begin
                    check("grant_timing", rise, pred_p);
                    if (rise) begin
                        w = last_m;
                        for (int k = 1; k <= N; k++) begin
                            if (req_p[(last_m + k) % N]) begin
                                w = (last_m + k) % N;
                                break;
                            end
                        end
                        last_m = w;
                        ea = addr_p[w]; ed = wdata_p[w]; ew = wr_p[w];
                        lat = lat_tab[mn % TAB];
                        e.id = w;
                        if (lat + 1 <= T) begin
                            e.cyc = cyc + lat + 1; e.err = 0; e.rd = prd_tab[mn % TAB];
                            pen_end = cyc + lat;
                        end else begin
                            e.cyc = cyc + T; e.err = 1; e.rd = ERR;
                            pen_end = cyc + T - 1;
                        end
                        mn++;
                        g = cyc;
                        gap_c = cyc + lat + 1;
                        free_from = cyc + lat + 2;
                        sbq.push_back(e);
                    end
                end
                check("penable", bus.penable, (cyc >= g && cyc <= pen_end));
                check("busy", bus.busy, (cyc >= g && cyc <= gap_c));
                check("grant_id", bus.grant_id, last_m);
                if (cyc >= g && cyc <= pen_end) begin
                    check("paddr", bus.paddr, ea);
                    check("pwdata", bus.pwdata, ed);
                    check("pwrite", bus.pwrite, ew);
                end
                if (bus.ack != '0) begin
                    if (sbq.size() == 0) begin
                        check("ack_unexpected", bus.ack, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("ack_cycle", cyc, e.cyc);
                        check("ack_onehot", bus.ack, 1 << e.id);
                        check("ack_err", bus.ack_err, e.err);
                        check("rdata", bus.rdata, e.rd);
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    e = sbq.pop_front();
                    check("ack_missing", 0, 1);
                end
                pred_p = (cyc >= free_from) && (bus.req != '0);
                req_p = bus.req;
                wr_p = bus.req_write;
                for (int i = 0; i < N; i++) begin
                    addr_p[i] = bus.req_addr[32*i +: 32];
                    wdata_p[i] = bus.req_wdata[32*i +: 32];
                end
                pen_p = bus.penable;
            end
        end
    end

    // ---------------- requester driver ----------------
    logic [N-1:0] r;
    logic [31:0]  a [N];
    logic [31:0]  d [N];
    logic [N-1:0] wv;
    int rereq_pct = 0, new_pct = 0, drop_pct = 0;
    bit scramble = 0;

    task automatic drive();
        bus.req = r;
        bus.req_write = wv;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[32*i +: 32] = a[i];
            bus.req_wdata[32*i +: 32] = d[i];
        end
    endtask

    task automatic rand_fields(input int i);
        a[i] = $urandom;
        d[i] = $urandom;
        wv[i] = 1'($urandom_range(1));
    endtask

    // One cycle: step to just after the edge, then apply requester policy.
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
                r[i] = ($urandom_range(99) < rereq_pct);
                rand_fields(i);
            end else if (!r[i]) begin
                rand_fields(i);
                if ($urandom_range(99) < new_pct) r[i] = 1'b1;
            end else if ($urandom_range(99) < drop_pct) begin
                r[i] = 1'b0;
            end else if (scramble && bus.busy && bus.grant_id == i) begin
                rand_fields(i);
            end
        end
        drive();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((r != '0 || bus.busy) && n < 300) begin
            tick();
            n++;
        end
        check(nm, (n < 300), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < TAB; i++) begin
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: lat_tab[i] = $urandom_range(6, 1);
                6, 7:             lat_tab[i] = $urandom_range(8, 7);
                default:          lat_tab[i] = $urandom_range(20, 9);
            endcase
            prd_tab[i] = $urandom;
        end
        lat_tab[0] = 3;  prd_tab[0] = 32'h1234_5678;
        lat_tab[1] = 3;
        lat_tab[2] = 19;
        lat_tab[3] = 7;  prd_tab[3] = 32'h0BAD_F00D;
        for (int i = 4; i < 40; i++) lat_tab[i] = 3;

        r = '0; wv = '0;
        for (int i = 0; i < N; i++) rand_fields(i);
        drive();
        repeat (3) @(posedge clk);
        #2;
        check("rst_penable", bus.penable, 0);
        check("rst_grant_id", bus.grant_id, N - 1);
        check("rst_rdata", bus.rdata, 0);
        reset_ = 1'b1;

        // single read from requester 0
        tick();
        a[0] = 32'h0100_0010; wv[0] = 1'b0; r[0] = 1'b1; drive();
        wait_idle("single_read_done");

        // write from requester 1
        a[1] = 32'h0200_1004; d[1] = 32'hA5A5_0001; wv[1] = 1'b1; r[1] = 1'b1; drive();
        wait_idle("write_done");

        // timeout on requester 0, then requester 1 with pready on the expiry cycle
        wv[0] = 1'b0; wv[1] = 1'b0; r[0] = 1'b1; r[1] = 1'b1; drive();
        wait_idle("timeout_done");

        // contention: everyone re-requests immediately
        rereq_pct = 100;
        r = '1; drive();
        repeat (60) tick();
        rereq_pct = 0;
        wait_idle("contention_done");

        // reset while a transfer is in BUSY
        rereq_pct = 100;
        r = '1; drive();
        n = 0;
        while (!bus.penable && n < 50) begin tick(); n++; end
        check("pre_reset_grant", bus.penable, 1);
        tick();
        tick();
        @(posedge clk);
        #4;
        reset_ = 1'b0;
        #1;
        check("arst_penable", bus.penable, 0);
        check("arst_ack", bus.ack, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_grant_id", bus.grant_id, N - 1);
        check("arst_paddr", bus.paddr, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_ = 1'b1;
        n = 0;
        while (!bus.penable && n < 50) begin tick(); n++; end
        check("post_reset_grant", bus.grant_id, 0);

        // randomised traffic
        rereq_pct = 60; new_pct = 30; drop_pct = 3; scramble = 1;
        repeat (3000) tick();
        rereq_pct = 0; new_pct = 0; drop_pct = 0; scramble = 0;
        wait_idle("random_done");
        repeat (4) tick();
        check("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
